// File: rtl/bram_port_arbiter_if.sv
// Requester/BRAM bundle for bram_port_arbiter.
// Ports: req_* per-requester flat fields, req_ready one-hot grant, rsp_* read return,
//        bram_* single-port BRAM side, lock_timeout forced-release pulse.
interface bram_port_arbiter_if #(
  parameter int NUM_REQ      = 2,
  parameter int MEMORY_DEPTH = 4092,
  parameter int DATA_WIDTH   = 16
);
  localparam int ADDR_W = $clog2(MEMORY_DEPTH);

  logic [NUM_REQ-1:0]            req_valid;
  logic [NUM_REQ-1:0]            req_lock;
  logic [NUM_REQ-1:0]            req_wr;
  logic [NUM_REQ*ADDR_W-1:0]     req_addr;
  logic [NUM_REQ*DATA_WIDTH-1:0] req_wdata;
  logic [NUM_REQ-1:0]            req_ready;
  logic [NUM_REQ-1:0]            rsp_valid;
  logic [DATA_WIDTH-1:0]         rsp_rdata;
  logic                          bram_wr;
  logic [DATA_WIDTH-1:0]         bram_data;
  logic [ADDR_W-1:0]             bram_address;
  logic [DATA_WIDTH-1:0]         bram_q;
  logic                          lock_timeout;

  // Environment side: requesters plus the BRAM instance.
  modport master (
    output req_valid, req_lock, req_wr, req_addr, req_wdata, bram_q,
    input  req_ready, rsp_valid, rsp_rdata, bram_wr, bram_data, bram_address, lock_timeout
  );

  // Arbiter side.
  modport slave (
    input  req_valid, req_lock, req_wr, req_addr, req_wdata, bram_q,
    output req_ready, rsp_valid, rsp_rdata, bram_wr, bram_data, bram_address, lock_timeout
  );
endinterface

// File: rtl/bram_port_arbiter.sv
// Round-robin arbiter sharing one single-port BRAM among NUM_REQ requesters, with burst lock.
// Ports: clk, rstN (async active-low), bus (slave modport: requests, grants, read responses,
//        BRAM write/address/data/q, lock_timeout). Grant is same-cycle; read data returns one cycle later.
module bram_port_arbiter #(
  parameter int NUM_REQ      = 2,
  parameter int MEMORY_DEPTH = 4092,
  parameter int DATA_WIDTH   = 16,
  parameter int MAX_LOCK     = 64
) (
  input  logic               clk,
  input  logic               rstN,
  bram_port_arbiter_if.slave bus
);
  localparam int ADDR_W = $clog2(MEMORY_DEPTH);
  localparam int ID_W   = $clog2(NUM_REQ);
  localparam int CNT_W  = $clog2(MAX_LOCK);

  typedef enum logic {
    S_IDLE,
    S_LOCKED
  } state_t;

  state_t            state, state_nxt;
  logic [ID_W-1:0]   rr_ptr, rr_ptr_nxt;
  logic [ID_W-1:0]   owner, owner_nxt;
  logic [CNT_W-1:0]  lock_cnt, lock_cnt_nxt;
  logic              timeout_nxt;
  logic              grant_vld;
  logic [ID_W-1:0]   grant_id;
  logic [NUM_REQ-1:0] ready;
  logic [NUM_REQ-1:0] rsp_valid_q;
  logic              timeout_q;

  function automatic logic [ID_W-1:0] inc_id(input logic [ID_W-1:0] id);
    if (int'(id) == NUM_REQ - 1) return '0;
    return id + ID_W'(1);
  endfunction

  // Grant selection. The IDLE scan runs from the highest offset down so the
  // requester closest to rr_ptr is the last (winning) assignment.
  always_comb begin
    int idx;
    idx       = 0;
    grant_vld = 1'b0;
    grant_id  = '0;
    if (state == S_LOCKED) begin
      grant_vld = bus.req_valid[owner];
      grant_id  = owner;
    end else begin
      for (int k = NUM_REQ - 1; k >= 0; k--) begin
        idx = int'(rr_ptr) + k;
        if (idx >= NUM_REQ) idx = idx - NUM_REQ;
        if (bus.req_valid[ID_W'(idx)]) begin
          grant_vld = 1'b1;
          grant_id  = ID_W'(idx);
        end
      end
    end
    // Nothing is granted while reset is asserted, so the BRAM sees no traffic.
    if (!rstN) grant_vld = 1'b0;
  end

  always_comb begin
    ready = '0;
    if (grant_vld) ready[grant_id] = 1'b1;
  end

  assign bus.req_ready    = ready;
  assign bus.bram_wr      = grant_vld & bus.req_wr[grant_id];
  assign bus.bram_address = grant_vld ? bus.req_addr[int'(grant_id)*ADDR_W +: ADDR_W] : '0;
  assign bus.bram_data    = grant_vld ? bus.req_wdata[int'(grant_id)*DATA_WIDTH +: DATA_WIDTH] : '0;
  assign bus.rsp_valid    = rsp_valid_q;
  assign bus.rsp_rdata    = bus.bram_q;
  assign bus.lock_timeout = timeout_q;

  // Next-state logic. lock_cnt counts LOCKED cycles; reaching MAX_LOCK-1
  // without a releasing beat forces the owner out. A beat accepted in that
  // final cycle still goes to the BRAM.
  always_comb begin
    state_nxt    = state;
    rr_ptr_nxt   = rr_ptr;
    owner_nxt    = owner;
    lock_cnt_nxt = lock_cnt;
    timeout_nxt  = 1'b0;
    case (state)
      S_IDLE: begin
        if (grant_vld) begin
          if (bus.req_lock[grant_id]) begin
            state_nxt    = S_LOCKED;
            owner_nxt    = grant_id;
            lock_cnt_nxt = '0;
          end else begin
            rr_ptr_nxt = inc_id(grant_id);
          end
        end
      end
      S_LOCKED: begin
        lock_cnt_nxt = lock_cnt + CNT_W'(1);
        if (grant_vld && !bus.req_lock[owner]) begin
          state_nxt  = S_IDLE;
          rr_ptr_nxt = inc_id(owner);
        end else if (lock_cnt == CNT_W'(MAX_LOCK - 1)) begin
          state_nxt   = S_IDLE;
          rr_ptr_nxt  = inc_id(owner);
          timeout_nxt = 1'b1;
        end
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rstN) begin
    if (!rstN) begin
      state       <= S_IDLE;
      rr_ptr      <= '0;
      owner       <= '0;
      lock_cnt    <= '0;
      rsp_valid_q <= '0;
      timeout_q   <= 1'b0;
    end else begin
      state       <= state_nxt;
      rr_ptr      <= rr_ptr_nxt;
      owner       <= owner_nxt;
      lock_cnt    <= lock_cnt_nxt;
      timeout_q   <= timeout_nxt;
      // BRAM q is valid the cycle after the address is presented.
      rsp_valid_q <= (grant_vld && !bus.req_wr[grant_id]) ? ready : '0;
    end
  end
endmodule

// File: tb/tb_bram_port_arbiter.sv
// Directed bench for bram_port_arbiter with a behavioural single-port BRAM.
// Ports: none; drives the interface master side, models BRAM q, checks grants/responses/timeout.
module tb_bram_port_arbiter;
  localparam int NR    = 2;
  localparam int DEPTH = 4092;
  localparam int DW    = 16;
  localparam int ML    = 8;
  localparam int AW    = $clog2(DEPTH);

  logic clk = 1'b0;
  logic rstN;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  bram_port_arbiter_if #(.NUM_REQ(NR), .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW)) bif ();

  bram_port_arbiter #(
    .NUM_REQ(NR), .MEMORY_DEPTH(DEPTH), .DATA_WIDTH(DW), .MAX_LOCK(ML)
  ) dut (
    .clk (clk),
    .rstN(rstN),
    .bus (bif.slave)
  );

  // Single-port BRAM: registered address, write has priority over read.
  logic [DW-1:0] mem [0:(1<<AW)-1];
  always @(posedge clk) begin
    if (bif.bram_wr) mem[bif.bram_address] <= bif.bram_data;
    else             bif.bram_q <= mem[bif.bram_address];
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic set_req(input int i, input logic v, input logic lk, input logic wr,
                         input logic [AW-1:0] a, input logic [DW-1:0] d);
    bif.req_valid[i]          = v;
    bif.req_lock[i]           = lk;
    bif.req_wr[i]             = wr;
    bif.req_addr[i*AW +: AW]  = a;
    bif.req_wdata[i*DW +: DW] = d;
  endtask

  task automatic idle_all();
    for (int i = 0; i < NR; i++) set_req(i, 1'b0, 1'b0, 1'b0, '0, '0);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog simulation did not finish");
    $fatal(1);
  end

  initial begin
    rstN = 1'b0;
    idle_all();
    bif.bram_q = '0;
    set_req(0, 1'b1, 1'b0, 1'b1, 12'd3, 16'h5555);
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready", bif.req_ready, 2'b00);
    chk("rst_rsp", bif.rsp_valid, 2'b00);
    chk("rst_tmo", bif.lock_timeout, 1'b0);
    chk("rst_wr", bif.bram_wr, 1'b0);
    chk("rst_addr", bif.bram_address, 12'd0);
    chk("rst_data", bif.bram_data, 16'h0000);
    rstN = 1'b1;
    idle_all();
    @(negedge clk);

    // 1: preload mem[5] through req0, then read it back
    set_req(0, 1'b1, 1'b0, 1'b1, 12'd5, 16'h1234);
    #1;
    chk("t1_wr_ready", bif.req_ready, 2'b01);
    chk("t1_wr_en", bif.bram_wr, 1'b1);
    chk("t1_wr_addr", bif.bram_address, 12'd5);
    chk("t1_wr_data", bif.bram_data, 16'h1234);
    @(negedge clk);
    chk("t1_no_rsp_wr", bif.rsp_valid, 2'b00);
    set_req(0, 1'b1, 1'b0, 1'b0, 12'd5, 16'h0000);
    #1;
    chk("t1_rd_ready", bif.req_ready, 2'b01);
    chk("t1_rd_wr", bif.bram_wr, 1'b0);
    chk("t1_rd_addr", bif.bram_address, 12'd5);
    @(negedge clk);
    chk("t1_rsp_vld", bif.rsp_valid, 2'b01);
    chk("t1_rsp_dat", bif.rsp_rdata, 16'h1234);
    idle_all();

    // 2: req1 write then read same address back-to-back
    set_req(1, 1'b1, 1'b0, 1'b1, 12'h010, 16'hBEEF);
    #1;
    chk("t2_wr_ready", bif.req_ready, 2'b10);
    chk("t2_wr_en", bif.bram_wr, 1'b1);
    chk("t2_wr_addr", bif.bram_address, 12'h010);
    chk("t2_wr_data", bif.bram_data, 16'hBEEF);
    @(negedge clk);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0000);
    chk("t2_no_rsp_wr", bif.rsp_valid, 2'b00);
    #1;
    chk("t2_rd_ready", bif.req_ready, 2'b10);
    @(negedge clk);
    chk("t2_rsp_vld", bif.rsp_valid, 2'b10);
    chk("t2_rsp_dat", bif.rsp_rdata, 16'hBEEF);
    idle_all();

    // 3: both requesting continuously, pointer at 0 -> alternate 0,1,0,1
    set_req(0, 1'b1, 1'b0, 1'b0, 12'd5, 16'h0000);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0000);
    for (int k = 0; k < 6; k++) begin
      #1;
      chk("t3_ready", bif.req_ready, (k % 2 == 0) ? 2'b01 : 2'b10);
      @(negedge clk);
      chk("t3_rsp_vld", bif.rsp_valid, (k % 2 == 0) ? 2'b01 : 2'b10);
      chk("t3_rsp_dat", bif.rsp_rdata, (k % 2 == 0) ? 16'h1234 : 16'hBEEF);
    end
    idle_all();

    // 4: req0 locked burst (1,1,gap,1,0) while req1 waits
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0000);
    for (int b = 0; b < 4; b++) begin
      set_req(0, 1'b1, (b < 3) ? 1'b1 : 1'b0, 1'b0, 12'd5, 16'h0000);
      #1;
      chk("t4_burst_ready", bif.req_ready, 2'b01);
      @(negedge clk);
      if (b == 1) begin
        set_req(0, 1'b0, 1'b0, 1'b0, 12'd5, 16'h0000);
        #1;
        chk("t4_gap_ready", bif.req_ready, 2'b00);
        chk("t4_gap_addr", bif.bram_address, 12'd0);
        @(negedge clk);
      end
    end
    set_req(0, 1'b0, 1'b0, 1'b0, 12'd0, 16'h0000);
    #1;
    chk("t4_req1_ready", bif.req_ready, 2'b10);
    @(negedge clk);
    chk("t4_req1_rsp", bif.rsp_valid, 2'b10);
    idle_all();

    // 5: req0 holds lock forever -> forced release after ML locked cycles
    set_req(0, 1'b1, 1'b1, 1'b0, 12'd5, 16'h0000);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0000);
    for (int c = 0; c <= ML; c++) begin
      #1;
      chk("t5_lock_ready", bif.req_ready, 2'b01);
      chk("t5_no_tmo", bif.lock_timeout, 1'b0);
      @(negedge clk);
    end
    #1;
    chk("t5_tmo", bif.lock_timeout, 1'b1);
    chk("t5_req1_ready", bif.req_ready, 2'b10);
    set_req(0, 1'b0, 1'b0, 1'b0, 12'd0, 16'h0000);
    @(negedge clk);
    chk("t5_tmo_pulse", bif.lock_timeout, 1'b0);
    chk("t5_req1_rsp", bif.rsp_valid, 2'b10);
    idle_all();

    // 6: reset right after a read accept drops the response and the pointer
    set_req(0, 1'b1, 1'b0, 1'b0, 12'd5, 16'hAAAA);
    set_req(1, 1'b1, 1'b0, 1'b0, 12'h010, 16'h0000);
    #1;
    chk("t6_pre_ready", bif.req_ready, 2'b01);
    @(posedge clk);
    #1;
    rstN = 1'b0;
    #1;
    chk("t6_rst_rsp", bif.rsp_valid, 2'b00);
    chk("t6_rst_ready", bif.req_ready, 2'b00);
    chk("t6_rst_wr", bif.bram_wr, 1'b0);
    chk("t6_rst_addr", bif.bram_address, 12'd0);
    chk("t6_rst_data", bif.bram_data, 16'h0000);
    chk("t6_rst_tmo", bif.lock_timeout, 1'b0);
    @(negedge clk);
    chk("t6_rst_rsp2", bif.rsp_valid, 2'b00);
    @(negedge clk);
    rstN = 1'b1;
    #1;
    chk("t6_post_ready", bif.req_ready, 2'b01);
    @(negedge clk);
    chk("t6_post_rsp", bif.rsp_valid, 2'b01);
    chk("t6_post_dat", bif.rsp_rdata, 16'h1234);
    idle_all();
    @(negedge clk);

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end
endmodule
